// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector.
// Contents:
//   ctrl_state_e : controller FSM encoding (idle / armed / shifting)
//   clamp_len()  : forces a requested pattern length into 1..max_len
package seq_det_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StShift = 2'd2
  } ctrl_state_e;

  // Zero is treated as 1 so the matcher always compares at least one bit.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Overlapping Mealy matcher: bit history, fill level, compare, registered match
// pulse and saturating match counter.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bit_valid    : bit_x carries a serial bit this cycle
//   bit_x        : serial bit
//   pattern, len : pattern and clamped length (1..PAT_W); bit [len-1] meets the oldest bit
//   clear        : zero count, history and fill; suppresses a same-cycle hit
//   restart      : zero history and fill only
//   match        : registered pulse one cycle after the completing bit
//   match_count  : saturating number of matches
//   count_next   : value match_count takes on the next edge
module seq_match_core #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_x,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             clear,
  input  logic             restart,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] count_next
);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match_q, match_d;
  logic [PAT_W-1:0] window, mask;
  logic [LEN_W:0]   fill_p1;
  logic             hit;

  always_comb begin
    window  = {hist_q, bit_x};
    mask    = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    // The incoming bit counts towards the window, so len-1 stored bits suffice.
    fill_p1 = {1'b0, fill_q} + (LEN_W + 1)'(1);
    hit     = bit_valid && ((window & mask) == (pattern & mask)) && (fill_p1 >= {1'b0, len});

    hist_d  = hist_q;
    fill_d  = fill_q;
    count_d = count_q;
    match_d = hit;
    if (bit_valid) begin
      hist_d = window[PAT_W-2:0];
      if (fill_q != LEN_W'(PAT_W)) fill_d = fill_q + LEN_W'(1);
    end
    if (hit && (count_q != '1)) count_d = count_q + CNT_W'(1);
    if (restart) begin
      hist_d = '0;
      fill_d = '0;
    end
    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign count_next  = count_d;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Streaming controller: accepts words over valid/ready, serialises them MSB-first
// into seq_match_core and raises an optional threshold interrupt.
// Build option: define SEQ_CTRL_IRQ_EN to enable the sticky irq; otherwise irq is 0
// and cfg_thresh / irq_ack are ignored.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cfg_start / cfg_stop / cfg_clear : arm (idle only) / return to idle / zero count+history
//   cfg_pattern, cfg_len           : pattern and length, latched on start
//   cfg_thresh, irq_ack            : irq threshold and acknowledge
//   in_valid, in_ready, in_data    : word handshake
//   busy, bit_x, bit_valid         : FSM not idle, serial bit tap
//   match, match_count, irq        : detection outputs
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     cfg_stop,
  input  logic                     cfg_clear,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic [$clog2(PAT_W):0]   cfg_len,
  input  logic [CNT_W-1:0]         cfg_thresh,
  input  logic                     irq_ack,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W-1:0]        in_data,
  output logic                     busy,
  output logic                     bit_x,
  output logic                     bit_valid,
  output logic                     match,
  output logic [CNT_W-1:0]         match_count,
  output logic                     irq
);

  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;
  localparam int unsigned IDX_W = $clog2(WORD_W);

  ctrl_state_e       state_q, state_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              restart;
  logic [CNT_W-1:0]  count_next;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    word_d    = word_q;
    idx_d     = idx_q;
    stop_d    = stop_q;
    restart   = 1'b0;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    bit_x     = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d   = StArmed;
          pattern_d = cfg_pattern;
          len_d     = LEN_W'(clamp_len(32'(cfg_len), PAT_W));
          restart   = 1'b1;
        end
      end
      StArmed: begin
        // A stop request wins over a pending word.
        in_ready = !cfg_stop;
        if (cfg_stop) begin
          state_d = StIdle;
        end else if (in_valid) begin
          word_d  = in_data;
          idx_d   = IDX_W'(WORD_W - 1);
          stop_d  = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        bit_valid = 1'b1;
        bit_x     = word_q[idx_q];
        // Stop is deferred until the word has been fully shifted.
        if (cfg_stop) stop_d = 1'b1;
        if (idx_q == '0) begin
          state_d = (stop_q || cfg_stop) ? StIdle : StArmed;
          stop_d  = 1'b0;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      len_q     <= LEN_W'(1);
      word_q    <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
    end
  end

  seq_match_core #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid   (bit_valid),
    .bit_x       (bit_x),
    .pattern     (pattern_q),
    .len         (len_q),
    .clear       (cfg_clear),
    .restart     (restart),
    .match       (match),
    .match_count (match_count),
    .count_next  (count_next)
  );

`ifdef SEQ_CTRL_IRQ_EN
  logic irq_q, irq_set;

  // Fires only on the edge where the count actually steps onto the threshold.
  assign irq_set = (cfg_thresh != '0) && (count_next == cfg_thresh) &&
                   (count_next != match_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_set | (irq_q & ~irq_ack);
  end

  assign irq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{cfg_thresh, irq_ack, count_next};
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: stimulus pushes expected match events
// (word number, bit position, count, irq); a negedge monitor pops and compares.
module tb_seq_detect_ctrl;

`ifdef SEQ_CTRL_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk, rst_n;
  logic        cfg_start, cfg_stop, cfg_clear, irq_ack;
  logic [3:0]  cfg_pattern;
  logic [2:0]  cfg_len;
  logic [15:0] cfg_thresh;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        busy, bit_x, bit_valid, match, irq;
  logic [15:0] match_count;

  seq_detect_ctrl #(
    .WORD_W (8),
    .PAT_W  (4),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_stop    (cfg_stop),
    .cfg_clear   (cfg_clear),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_thresh  (cfg_thresh),
    .irq_ack     (irq_ack),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .busy        (busy),
    .bit_x       (bit_x),
    .bit_valid   (bit_valid),
    .match       (match),
    .match_count (match_count),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int word;
    int bpos;
    int count;
    bit irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   stim_words = 0;
  int   mon_word = 0;
  int   mon_bpos = 0;
  bit   prev_bv = 1'b0;

  // Monitor: a word starts where bit_valid rises; match refers to the previous bit.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (match) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_match word=%0d bit=%0d count=%0d", mon_word, mon_bpos,
                   match_count);
        end else begin
          e = exp_q.pop_front();
          if (e.word != mon_word || e.bpos != mon_bpos || e.count != int'(match_count) ||
              e.irq != irq) begin
            failures++;
            $display("FAIL match_event actual word=%0d bit=%0d count=%0d irq=%0d required word=%0d bit=%0d count=%0d irq=%0d",
                     mon_word, mon_bpos, match_count, irq, e.word, e.bpos, e.count, e.irq);
          end
        end
      end
      if (bit_valid) begin
        if (!prev_bv) begin
          mon_word++;
          mon_bpos = 1;
        end else begin
          mon_bpos++;
        end
      end
      prev_bv = bit_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int woff, input int bpos, input int cnt, input bit irq_e);
    exp_t e;
    e.word  = stim_words + woff;
    e.bpos  = bpos;
    e.count = cnt;
    e.irq   = irq_e;
    exp_q.push_back(e);
  endtask

  // 0 start, 1 stop, 2 clear, 3 irq_ack
  task automatic pulse(input int which);
    tick();
    case (which)
      0: cfg_start = 1'b1;
      1: cfg_stop  = 1'b1;
      2: cfg_clear = 1'b1;
      default: irq_ack = 1'b1;
    endcase
    tick();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    cfg_clear = 1'b0;
    irq_ack   = 1'b0;
  endtask

  // Returns one tick after the accepting edge, i.e. during the first shifted bit.
  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    tick();
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout actual=0 required=1");
    end
    tick();
    in_valid = 1'b0;
    stim_words++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy && !in_ready && n < 40) begin
      tick();
      n++;
    end
    if (busy && !in_ready) begin
      checks++;
      failures++;
      $display("FAIL word_done_timeout actual=busy required=done");
    end
  endtask

  initial begin : stim
    int nb;
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_stop = 1'b0; cfg_clear = 1'b0; irq_ack = 1'b0;
    cfg_pattern = 4'b1011; cfg_len = 3'd4; cfg_thresh = 16'd0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_bit_valid", bit_valid, 0);
    check("reset_match", match, 0);
    check("reset_count", match_count, 0);
    check("reset_irq", irq, 0);

    // 1: two overlapping-window hits in one word, in_ready timing
    pulse(0);
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 1);
    push_exp(1, 4, 1, 1'b0);
    push_exp(1, 7, 2, 1'b0);
    send_word(8'b1011_0110);
    repeat (7) tick();
    check("t1_ready_low_bit8", in_ready, 0);
    tick();
    check("t1_ready_back_9", in_ready, 1);
    check("t1_count", match_count, 2);

    // 2: history spans words
    pulse(2);
    check("t2_clear_count", match_count, 0);
    push_exp(2, 1, 1, 1'b0);
    send_word(8'h05);
    wait_done();
    send_word(8'h80);
    wait_done();
    check("t2_count", match_count, 1);

    // 3: clear on the same edge as the bit-4 hit
    send_word(8'b1011_0110);
    repeat (3) tick();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    wait_done();
    check("t3_count_cleared", match_count, 0);
    push_exp(1, 4, 1, 1'b0);
    send_word(8'hB0);
    wait_done();
    check("t3_count_after", match_count, 1);

    // 4: stop during shift finishes the word then idles
    send_word(8'h00);
    nb = 0;
    cfg_stop = 1'b1;
    if (bit_valid) nb++;
    tick();
    cfg_stop = 1'b0;
    if (bit_valid) nb++;
    repeat (10) begin
      tick();
      if (bit_valid) nb++;
    end
    check("t4_bits_shifted", nb, 8);
    check("t4_busy", busy, 0);
    check("t4_in_ready", in_ready, 0);
    pulse(0);
    check("t4_rearm_ready", in_ready, 1);

    // 5: reset during bit 3 drops the word
    send_word(8'b1011_0110);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check("t5_busy", busy, 0);
    check("t5_count", match_count, 0);
    check("t5_match", match, 0);
    rst_n = 1'b1;
    pulse(0);
    send_word(8'hC0);
    wait_done();
    check("t5_no_stale_hit", match_count, 0);
    push_exp(1, 4, 1, 1'b0);
    push_exp(1, 7, 2, 1'b0);
    send_word(8'b1011_0110);
    wait_done();
    check("t5_count_after", match_count, 2);

    // 6: threshold interrupt
    cfg_thresh = 16'd2;
    pulse(2);
    push_exp(1, 4, 1, 1'b0);
    push_exp(1, 7, 2, IRQ_BUILD);
    send_word(8'b1011_0110);
    wait_done();
    check("t6_irq_set", irq, int'(IRQ_BUILD));
    repeat (3) tick();
    check("t6_irq_sticky", irq, int'(IRQ_BUILD));
    pulse(3);
    check("t6_irq_acked", irq, 0);

    // 7: len 0 clamps to 1; start while armed is ignored
    cfg_thresh = 16'd0;
    pulse(1);
    check("t7_idle", busy, 0);
    cfg_pattern = 4'b0001;
    cfg_len = 3'd0;
    pulse(0);
    pulse(2);
    cfg_pattern = 4'b0000;
    cfg_len = 3'd1;
    pulse(0);
    push_exp(1, 1, 1, 1'b0);
    push_exp(1, 3, 2, 1'b0);
    send_word(8'hA0);
    wait_done();
    check("t7_count", match_count, 2);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
